// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch front end: FSM state encoding,
// program-counter update selector, reset/NOP constants and the opcode field
// position inside a MIPS instruction word.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_FLUSH = 2'd3
  } fetch_state_t;

  // How the program counter moves at the next clock edge.
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

endpackage

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter and pending redirect target of the fetch unit.
//
// Ports:
//   clk          core clock, rising edge
//   reset        synchronous active-low reset
//   i_pc_sel     PC update: hold / +4 / load i_target / load pending target
//   i_pend_we    capture i_target as the pending redirect target
//   i_target     word-aligned redirect target
//   o_pc         current fetch address
//   o_pc_plus4   o_pc + 4 (modulo 2^DATA_WIDTH)
// -----------------------------------------------------------------------------
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = DATA_WIDTH'(PC_RESET_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  pc_sel_t               i_pc_sel,
  input  logic                  i_pend_we,
  input  logic [DATA_WIDTH-1:0] i_target,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_plus4
);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_pending;
  logic [DATA_WIDTH-1:0] w_pc_plus4;

  // Wraps silently past the top of the address space.
  assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= PC_RESET;
      r_pending <= '0;
    end else begin
      case (i_pc_sel)
        PC_INC:   r_pc <= w_pc_plus4;
        PC_REDIR: r_pc <= i_target;
        PC_PEND:  r_pc <= r_pending;
        default:  r_pc <= r_pc;
      endcase
      if (i_pend_we) begin
        r_pending <= i_target;
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Front end of the single-issue MIPS core. Owns the PC, fetches words from
// instruction memory over a req/ack handshake and holds each in the
// instruction register until the consumer takes it.
//
// Ports:
//   clk            core clock, rising edge
//   reset          synchronous active-low reset
//   stall_i        consumer cannot accept the presented instruction
//   redirect_i     taken branch/jump, next fetch from redirect_pc_i
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   imem_req_o     fetch request
//   imem_addr_o    word-aligned fetch address
//   imem_ack_i     memory returns imem_rdata_i this cycle
//   imem_rdata_i   fetched instruction word
//   instr_o        instruction register
//   op_o           instr_o[31:26], to the opcode decoder
//   pc_plus4_o     fetch address of instr_o plus 4
//   instr_valid_o  instr_o holds an unconsumed instruction
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = DATA_WIDTH'(PC_RESET_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [5:0]            op_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  instr_valid_o
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  pc_sel_t               w_pc_sel;
  logic                  w_pend_we;
  logic                  w_req;
  logic                  w_ack;
  logic                  w_capture;
  logic                  w_squash;
  logic [DATA_WIDTH-1:0] w_pc;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc_plus4;

  assign w_target = redirect_pc_i & ~DATA_WIDTH'(3);

  fetch_pc_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_RESET   (PC_RESET)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_pc_sel   (w_pc_sel),
    .i_pend_we  (w_pend_we),
    .i_target   (w_target),
    .o_pc       (w_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  // In S_VALID a request goes out only when the current word is being
  // consumed, so a stalled instruction never has a successor in flight.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_REQ, S_FLUSH: w_req = 1'b1;
      S_VALID:        w_req = !stall_i;
      default:        w_req = 1'b0;
    endcase
  end

  // An ack without a request is not a handshake.
  assign w_ack = w_req & imem_ack_i;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_sel    = PC_HOLD;
    w_pend_we   = 1'b0;
    w_capture   = 1'b0;
    w_squash    = 1'b0;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_ack) begin
          w_capture   = 1'b1;
          w_pc_sel    = PC_INC;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall_i) begin
          if (w_ack) begin
            w_capture = 1'b1;
            w_pc_sel  = PC_INC;
          end else begin
            // The request raised this cycle keeps its address in S_REQ.
            w_state_nxt = S_REQ;
          end
        end
      end
      S_FLUSH: begin
        // Data returned for the stale address is dropped.
        if (w_ack) begin
          w_pc_sel    = PC_PEND;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Redirect overrides everything above. An unacked request must finish
    // at its original address, so the target is parked until then.
    if (redirect_i) begin
      w_squash  = 1'b1;
      w_capture = 1'b0;
      if (!w_req || w_ack) begin
        w_pc_sel    = PC_REDIR;
        w_state_nxt = S_REQ;
      end else begin
        w_pc_sel    = PC_HOLD;
        w_pend_we   = 1'b1;
        w_state_nxt = S_FLUSH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= '0;
    end else if (w_squash) begin
      r_instr <= NOP_WORD;
    end else if (w_capture) begin
      r_instr    <= imem_rdata_i;
      r_pc_plus4 <= w_pc_plus4;
    end
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = w_pc;
  assign instr_o       = r_instr;
  assign op_o          = r_instr[OP_MSB:OP_LSB];
  assign pc_plus4_o    = r_pc_plus4;
  assign instr_valid_o = (r_state == S_VALID);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench for instruction_fetch_unit: a behavioural instruction
// memory with programmable ack latency, a fetch-address / instruction
// scoreboard, a cycle vector table and hand-written corner sequences.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [5:0]  op_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;

  logic        force_ack;
  logic        mon_en;
  int          req_age;
  int          lat;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pp4;
  } ins_t;

  logic [31:0] exp_addr_q[$];
  ins_t        exp_ins_q[$];

  typedef struct {
    logic        stall;
    logic        redir;
    logic        fack;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pp4;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .op_o          (op_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_valid_o (instr_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h2008_0005;
      32'h0040_0004: return 32'h3509_000F;
      32'h0040_0008: return 32'h0109_5020;
      default:       return {6'h23, a[27:2]};
    endcase
  endfunction

  // Memory: acks once the request has been held for 'lat' earlier cycles.
  assign imem_rdata_i = mem_word(imem_addr_o);
  assign imem_ack_i   = (imem_req_o && (req_age >= lat)) || force_ack;

  always @(posedge clk) begin
    if (!imem_req_o || imem_ack_i) req_age <= 0;
    else                           req_age <= req_age + 1;
  end

  function automatic vec_t mk(input logic s, input logic r, input logic fa,
                              input logic [31:0] rpc, input logic rq,
                              input logic [31:0] ad, input logic v,
                              input logic [31:0] ins, input logic [31:0] pp4);
    vec_t t;
    t.stall = s;  t.redir = r;  t.fack = fa;  t.rpc = rpc;
    t.req = rq;   t.addr = ad;  t.valid = v;  t.instr = ins;  t.pp4 = pp4;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    check(name, {31'b0, got}, {31'b0, exp});
  endtask

  // Called once per cycle after inputs are applied at the falling edge.
  task automatic settle();
    ins_t e;
    #1;
    if (mon_en) begin
      if (imem_req_o && imem_ack_i) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_addr_underflow: ack at %h, none expected", imem_addr_o);
        end else begin
          check("sb_fetch_addr", imem_addr_o, exp_addr_q.pop_front());
        end
      end
      if (instr_valid_o && !stall_i) begin
        if (exp_ins_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_instr_underflow: consumed %h, none expected", instr_o);
        end else begin
          e = exp_ins_q.pop_front();
          check("sb_instr", instr_o, e.instr);
          check("sb_pc_plus4", pc_plus4_o, e.pp4);
          check("sb_op", {26'b0, op_o}, {26'b0, e.instr[31:26]});
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check1({tag, "_req"}, imem_req_o, 1'b0);
    check1({tag, "_valid"}, instr_valid_o, 1'b0);
    check({tag, "_instr"}, instr_o, 32'h0);
    check({tag, "_pc_plus4"}, pc_plus4_o, 32'h0);
    check({tag, "_op"}, {26'b0, op_o}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wc;
    logic [31:0] w200;
    logic [31:0] wtop;
    ins_t        t;

    reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    force_ack = 1'b0; lat = 0; mon_en = 1'b0; n_checks = 0; n_fail = 0;

    wc   = mem_word(32'h0040_000C);
    w200 = mem_word(32'h0040_0200);
    wtop = mem_word(32'hFFFF_FFFC);

    // Per-cycle vectors starting in S_VALID with pc=0x00400010, holding the
    // word from 0x0040000C; zero-wait memory.
    vecs[0] = mk(1'b1, 1'b1, 1'b1, 32'h0040_0203, 1'b0, 32'h0040_0010, 1'b1, wc,   32'h0040_0010);
    vecs[1] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0200, 1'b0, 32'h0, 32'h0040_0010);
    vecs[2] = mk(1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0040_0204, 1'b1, w200, 32'h0040_0204);
    vecs[3] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0040_0204, 1'b1, w200, 32'h0040_0204);
    vecs[4] = mk(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 32'h0040_0204, 1'b1, w200, 32'h0040_0204);
    vecs[5] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0040_0204);
    vecs[6] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1, wtop, 32'h0000_0000);
    vecs[7] = mk(1'b1, 1'b1, 1'b0, 32'h0040_0000, 1'b0, 32'h0000_0000, 1'b1, wtop, 32'h0000_0000);
    vecs[8] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0000, 1'b0, 32'h0, 32'h0000_0000);
    vecs[9] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0040_0004, 1'b1, 32'h2008_0005, 32'h0040_0004);

    // Reset state
    repeat (2) @(negedge clk);
    settle();
    check_reset_state("rst");

    // Zero-wait streaming, then a 4-cycle stall
    exp_addr_q.push_back(32'h0040_0000);
    exp_addr_q.push_back(32'h0040_0004);
    exp_addr_q.push_back(32'h0040_0008);
    exp_addr_q.push_back(32'h0040_000C);
    t.instr = 32'h2008_0005; t.pp4 = 32'h0040_0004; exp_ins_q.push_back(t);
    t.instr = 32'h3509_000F; t.pp4 = 32'h0040_0008; exp_ins_q.push_back(t);
    t.instr = 32'h0109_5020; t.pp4 = 32'h0040_000C; exp_ins_q.push_back(t);
    reset = 1'b1; mon_en = 1'b1;

    @(negedge clk); settle();
    check1("stream_valid_c1", instr_valid_o, 1'b0);
    check1("stream_req_c1", imem_req_o, 1'b1);
    @(negedge clk); settle();
    check1("stream_valid_c2", instr_valid_o, 1'b1);
    @(negedge clk); settle();
    @(negedge clk); stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      settle();
      check("stall_instr", instr_o, 32'h0109_5020);
      check("stall_pc_plus4", pc_plus4_o, 32'h0040_000C);
      check1("stall_valid", instr_valid_o, 1'b1);
      check1("stall_req", imem_req_o, 1'b0);
    end
    @(negedge clk); stall_i = 1'b0; settle();
    check1("release_req", imem_req_o, 1'b1);
    check("release_addr", imem_addr_o, 32'h0040_000C);
    mon_en = 1'b0;

    // Vector table: redirect with stall+ack, stray ack, wrap at top of memory
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      stall_i = vecs[i].stall; redirect_i = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc; force_ack = vecs[i].fack;
      settle();
      check1($sformatf("vec%0d_req", i), imem_req_o, vecs[i].req);
      check($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].addr);
      check1($sformatf("vec%0d_valid", i), instr_valid_o, vecs[i].valid);
      check($sformatf("vec%0d_instr", i), instr_o, vecs[i].instr);
      check($sformatf("vec%0d_pc_plus4", i), pc_plus4_o, vecs[i].pp4);
      check($sformatf("vec%0d_op", i), {26'b0, op_o}, {26'b0, vecs[i].instr[31:26]});
    end
    redirect_i = 1'b0; force_ack = 1'b0; redirect_pc_i = '0;

    // Slow memory (ack 3 cycles after req), then redirect into S_FLUSH
    @(negedge clk); reset = 1'b0; stall_i = 1'b0; lat = 3; settle();
    @(negedge clk); settle();
    check_reset_state("rst2");
    exp_addr_q.push_back(32'h0040_0000);
    exp_addr_q.push_back(32'h0040_0004);
    exp_addr_q.push_back(32'h0040_0008);
    t.instr = 32'h2008_0005; t.pp4 = 32'h0040_0004; exp_ins_q.push_back(t);
    t.instr = 32'h3509_000F; t.pp4 = 32'h0040_0008; exp_ins_q.push_back(t);
    reset = 1'b1; mon_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk); settle();
      check1("slow_req", imem_req_o, 1'b1);
      check("slow_addr", imem_addr_o, 32'h0040_0000);
      check1("slow_valid", instr_valid_o, 1'b0);
    end
    @(negedge clk); settle();
    check1("slow_valid_after_ack", instr_valid_o, 1'b1);
    check("slow_pc_plus4", pc_plus4_o, 32'h0040_0004);
    @(negedge clk); settle();
    check1("slow_valid_drop", instr_valid_o, 1'b0);
    check("slow_next_addr", imem_addr_o, 32'h0040_0004);
    repeat (3) begin @(negedge clk); settle(); end
    @(negedge clk); redirect_i = 1'b1; redirect_pc_i = 32'h0040_0103; settle();
    check1("flush_entry_req", imem_req_o, 1'b1);
    check("flush_entry_addr", imem_addr_o, 32'h0040_0008);
    @(negedge clk); redirect_i = 1'b0; redirect_pc_i = '0; settle();
    check1("flush_req", imem_req_o, 1'b1);
    check("flush_addr", imem_addr_o, 32'h0040_0008);
    check1("flush_valid", instr_valid_o, 1'b0);
    @(negedge clk); settle();
    check1("flush_ack_valid", instr_valid_o, 1'b0);
    @(negedge clk); settle();
    check1("flush_done_req", imem_req_o, 1'b1);
    check("flush_done_addr", imem_addr_o, 32'h0040_0100);
    check1("flush_done_valid", instr_valid_o, 1'b0);
    check("flush_done_instr", instr_o, 32'h0);
    mon_en = 1'b0;

    // Reset mid-request with an ack in the reset cycle
    @(negedge clk); reset = 1'b0; lat = 0; settle();
    @(negedge clk); settle();
    check_reset_state("rst_mid");
    reset = 1'b1;
    @(negedge clk); settle();
    check1("post_rst_req", imem_req_o, 1'b1);
    check("post_rst_addr", imem_addr_o, 32'h0040_0000);

    check("sb_addr_drained", 32'(exp_addr_q.size()), 32'h0);
    check("sb_instr_drained", 32'(exp_ins_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sequential front end of the single-issue MIPS core. It owns the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and holds each word in an instruction register.
- It presents op_o = instr_o[31:26] to the opcode decoder (the producer side of the decoder's OP input).
- Supports back-pressure (stall_i) and branch/jump redirection with flush of in-flight fetches.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- PC_RESET, 32'h0040_0000, first fetch address after reset.
- NOP_WORD, 32'h0000_0000, value loaded into the instruction register on reset and flush (sll $0,$0,0).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- stall_i  in  1  consumer cannot accept the presented instruction this cycle.
- redirect_i  in  1  taken branch/jump; next fetch comes from redirect_pc_i.
- redirect_pc_i  in  DATA_WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  DATA_WIDTH  word-aligned fetch address.
- imem_ack_i  in  1  memory returns imem_rdata_i this cycle.
- imem_rdata_i  in  DATA_WIDTH  fetched instruction word.
- instr_o  out  DATA_WIDTH  instruction register.
- op_o  out  6  instr_o[31:26], to the opcode decoder.
- pc_plus4_o  out  DATA_WIDTH  fetch address of instr_o plus 4.
- instr_valid_o  out  1  instr_o holds an unconsumed instruction.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=S_IDLE, pc_q=PC_RESET, instr_o=NOP_WORD, pc_plus4_o=0, instr_valid_o=0, imem_req_o=0, pending target=0.
  - Reset wins over every other input, including mid-handshake; an ack arriving in the reset cycle is dropped.
- States:
  - S_IDLE: req=0. Always goes to S_REQ next cycle, with redirect applied if present.
  - S_REQ: req=1, addr=pc_q, valid=0.
    - On ack: instr<=rdata, pc_plus4<=pc_q+4, pc_q<=pc_q+4, valid<=1, go to S_VALID.
    - No ack: stay in S_REQ.
  - S_VALID: valid=1; req = !stall_i.
    - stall_i=1: hold all registers.
    - stall_i=0 with ack: capture the new word as in S_REQ and stay in S_VALID. This gives 1 instr/clk throughput with a zero-wait memory.
    - stall_i=0 without ack: valid<=0, go to S_REQ.
  - S_FLUSH: req=1, addr=pc_q (the old address, held stable). On ack: discard the data, pc_q<=pending target, go to S_REQ.
- Handshake rules:
  - Once req is asserted with an address, req and addr stay unchanged until ack. The S_VALID→S_REQ path preserves this.
  - Ack while req=0 is ignored.
  - Memory may ack in the same cycle as req (combinational) or any later cycle.
- Redirect (priority over stall and ack), in any non-reset state:
  - instr<=NOP_WORD, valid<=0.
  - If no request is outstanding this cycle, or ack arrives this cycle: pc_q<=redirect_pc_i & ~3, go to S_REQ, and discard any acked data.
  - If a request is outstanding and unacked: pending<=target, go to S_FLUSH.
  - A redirect while in S_FLUSH overwrites pending (last target wins).
- Arithmetic: pc increment is modulo 2^DATA_WIDTH. 32'hFFFF_FFFC wraps to 0 with no error flag.
- op_o is combinational from instr_o. Valid never rises without a captured ack.

Decomposition:
- Shared package fetch_pkg: state encoding (S_IDLE, S_REQ, S_VALID, S_FLUSH, 2 bits), NOP_WORD, PC_RESET default, OP field slice constants (OP_MSB=31, OP_LSB=26).
- One sub-module: fetch_pc_reg. It holds pc_q and pending target, with load/increment/redirect select and synchronous active-low reset.
- The FSM and instruction register stay in the top.

Test Plan:
- Reset release, zero-wait memory returning 0x2008_0005, 0x3509_000F, 0x0109_5020 → addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles. op_o = 0x08, 0x0D, 0x00. instr_valid_o high from the second cycle after reset release.
- Memory acks 3 cycles after req → req and addr stable for all 3 cycles. valid rises the cycle after ack. pc_plus4_o=0x00400004.
- stall_i held 4 cycles while valid → instr_o, pc_plus4_o, valid unchanged. imem_req_o=0 throughout. Next fetch addr follows on release.
- Redirect to 0x00400103 while a request to 0x00400008 is unacked → FSM enters S_FLUSH. Ack on 0x00400008 is discarded; valid stays 0. Next request addr is 0x00400100.
- Redirect coincident with stall_i=1 and ack → ack data dropped, instr_o=0, valid=0. Next addr is the target.
- reset asserted mid-request → next cycle req=0, valid=0, instr_o=0. First post-reset address is 0x00400000.
